// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Optional feature macro used by fetch_stage: FETCH_PERF_EN.
package fetch_stage_pkg;
  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INST_BYTES   = 4;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the memory, downstream and redirect signals of the fetch stage.
// master = the fetch stage itself, slave = its environment.
interface fetch_stage_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_pc, inst_data,
    input  imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_pc, inst_data,
    output imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage_queue.sv
// Circular buffer of fetched {pc, instruction} entries with push/pop/flush.
// Head is read straight from registered storage; DEPTH must be a power of two.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   head_valid_o,
  output logic [WIDTH-1:0]       head_data_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !flush_i;
  assign pop_ok  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    count_d = count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_data_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, credit-based issue, epoch-tagged responses.
// Define FETCH_PERF_EN to add saturating stall/flush performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
`ifdef FETCH_PERF_EN
  output logic [31:0]  perf_stall_cycles,
  output logic [31:0]  perf_flushes,
`endif
  fetch_stage_if.master bus
);
  localparam int              CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(QUEUE_DEPTH);

  logic [XLEN-1:0]   fetch_pc_q;
  logic [XLEN-1:0]   fetch_pc_d;
  logic [XLEN-1:0]   inflight_pc_q;
  logic              inflight_q;
  logic              inflight_epoch_q;
  logic              epoch_q;
  logic              run_q;

  logic [CNT_W-1:0]  count;
  logic              head_valid;
  logic [2*XLEN-1:0] head_data;
  logic [CNT_W:0]    credit_used;
  logic              pop;
  logic              push;
  logic              issue;

  assign pop = head_valid && bus.inst_ready;

  // Slots already committed: buffered entries that stay plus the one in flight.
  always_comb begin
    credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    issue       = run_q && !bus.redirect_valid && (credit_used < DEPTH_C);
    push        = bus.imem_rvalid && inflight_q && (inflight_epoch_q == epoch_q)
                  && !bus.redirect_valid;
    fetch_pc_d  = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
    end
  end

  // run_q keeps imem_req low while reset is asserted and for the release cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q       <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
      run_q            <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q    <= fetch_pc_q;
        inflight_epoch_q <= epoch_q;
      end
      if (bus.redirect_valid) begin
        epoch_q <= ~epoch_q;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_queue (
    .clk          (clk),
    .rst_n        (reset),
    .flush_i      (bus.redirect_valid),
    .push_i       (push),
    .push_data_i  ({inflight_pc_q, bus.imem_rdata}),
    .pop_i        (pop),
    .count_o      (count),
    .head_valid_o (head_valid),
    .head_data_o  (head_data)
  );

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = head_valid;
  assign bus.inst_pc    = head_data[2*XLEN-1:XLEN];
  assign bus.inst_data  = head_data[XLEN-1:0];

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (head_valid && !bus.inst_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bus.redirect_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flushes      = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// scored against an in-order expected-PC stream and an address-derived memory.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  fetch_stage #(
    .XLEN        (32),
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
`ifdef FETCH_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
`endif
    .bus               (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  // Reference state: next address to be requested, next PC to be delivered.
  logic [31:0] exp_fetch, exp_deliv;
  int          cyc, deliv_cnt, req_cnt;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_data;
  logic        hold_prev;
  logic [31:0] hold_pc, hold_data;
  logic        mem_pend;
  logic [31:0] mem_pend_addr;

  // One clock: sample at negedge, score, then drive the memory response.
  task automatic cycle();
    @(negedge clk);
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.inst_valid;
    s_pc    = bus.inst_pc;
    s_data  = bus.inst_data;
    if (hold_prev) begin
      chk("hold_valid", {31'b0, s_valid}, 32'd1);
      chk("hold_pc", s_pc, hold_pc);
      chk("hold_data", s_data, hold_data);
    end
    if (bus.redirect_valid) begin
      chk("req_on_redirect", {31'b0, s_req}, 32'd0);
    end else if (s_req) begin
      chk("fetch_addr", s_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      req_cnt++;
    end
    if (s_valid && bus.inst_ready) begin
      chk("deliv_pc", s_pc, exp_deliv);
      chk("deliv_data", s_data, mem_word(exp_deliv));
      exp_deliv = exp_deliv + 32'd4;
      deliv_cnt++;
    end
    if (bus.redirect_valid) begin
      exp_fetch = bus.redirect_pc & ~32'd3;
      exp_deliv = bus.redirect_pc & ~32'd3;
    end
    hold_prev     = s_valid && !bus.inst_ready && !bus.redirect_valid;
    hold_pc       = s_pc;
    hold_data     = s_data;
    mem_pend      = s_req;
    mem_pend_addr = s_addr;
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_rvalid = mem_pend;
    bus.imem_rdata  = mem_pend ? mem_word(mem_pend_addr) : 32'h0;
  endtask

  task automatic do_reset(input logic stray);
    reset = 1'b0;
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_pc", bus.inst_pc, 32'd0);
    chk("rst_data", bus.inst_data, 32'd0);
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    exp_fetch = RST_PC;
    exp_deliv = RST_PC;
    hold_prev = 1'b0;
    mem_pend  = 1'b0;
    req_cnt   = 0;
    bus.imem_rvalid = stray;
    bus.imem_rdata  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_req(input string tag);
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (s_req) break;
    end
    chk(tag, {31'b0, s_req}, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (s_valid) break;
    end
    chk(tag, {31'b0, s_valid}, 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    cycle();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    int c_req, c_val, d0;
    cyc = 0;
    deliv_cnt = 0;
    req_cnt = 0;

    // Startup latency and steady streaming
    do_reset(1'b0);
    bus.inst_ready = 1'b1;
    wait_req("t1_req_seen");
    c_req = cyc;
    chk("t1_first_addr", s_addr, RST_PC);
    wait_valid("t1_valid_seen");
    c_val = cyc;
    chk("t1_latency", 32'(c_val - c_req), 32'd2);
    chk("t1_pc0", s_pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("t1_stream_valid", {31'b0, s_valid}, 32'd1);
      chk("t1_stream_pc", s_pc, 32'(4 * i));
    end

    // Back-pressure fills the queue to two entries
    do_reset(1'b0);
    bus.inst_ready = 1'b0;
    wait_valid("t2_valid_seen");
    chk("t2_head0", s_pc, 32'h0);
    repeat (5) cycle();
    chk("t2_req_dropped", {31'b0, s_req}, 32'd0);
    chk("t2_head_stable", s_pc, 32'h0);
    chk("t2_issued", 32'(req_cnt), 32'd2);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_release_valid", {31'b0, s_valid}, 32'd1);
      chk("t2_release_pc", s_pc, 32'(4 * i));
    end

    // Redirect while the request for 0x8 is in flight
    do_reset(1'b0);
    bus.inst_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (s_req && s_addr == 32'h8) break;
    end
    chk("t3_req8", s_addr, 32'h8);
    redirect_to(32'h100);
    cycle();
    chk("t3_new_req", {31'b0, s_req}, 32'd1);
    chk("t3_new_addr", s_addr, 32'h100);
    chk("t3_empty1", {31'b0, s_valid}, 32'd0);
    cycle();
    chk("t3_empty2", {31'b0, s_valid}, 32'd0);
    cycle();
    chk("t3_valid", {31'b0, s_valid}, 32'd1);
    chk("t3_pc", s_pc, 32'h100);

    // Misaligned redirect target
    redirect_to(32'h203);
    cycle();
    chk("t4_req", {31'b0, s_req}, 32'd1);
    chk("t4_addr", s_addr, 32'h200);

    // Redirect coinciding with a head handshake
    bus.inst_ready = 1'b0;
    repeat (6) cycle();
    chk("t5_full", {31'b0, s_valid}, 32'd1);
    bus.inst_ready = 1'b1;
    d0 = deliv_cnt;
    redirect_to(32'h400);
    chk("t5_consumed_once", 32'(deliv_cnt - d0), 32'd1);
    wait_valid("t5_valid_seen");
    chk("t5_pc", s_pc, 32'h400);

    // Address wrap past the top of memory
    redirect_to(32'hFFFF_FFF8);
    wait_valid("t7_valid_seen");
    chk("t7_pc_a", s_pc, 32'hFFFF_FFF8);
    cycle();
    chk("t7_pc_b", s_pc, 32'hFFFF_FFFC);
    cycle();
    chk("t7_pc_wrap", s_pc, 32'h0);

    // Reset with a full queue, followed by a stray response
    bus.inst_ready = 1'b0;
    repeat (6) cycle();
    chk("t6_full", {31'b0, s_valid}, 32'd1);
    do_reset(1'b1);
    bus.inst_ready = 1'b1;
    cycle();
    chk("t6_stray_dropped", {31'b0, s_valid}, 32'd0);
    wait_req("t6_req_seen");
    chk("t6_restart_addr", s_addr, RST_PC);
    wait_valid("t6_valid_seen");
    chk("t6_restart_pc", s_pc, RST_PC);
    chk("t6_restart_data", s_data, mem_word(RST_PC));

    // Randomized traffic against the scoreboard
    d0 = deliv_cnt;
    for (int n = 0; n < 3000; n++) begin
      bus.inst_ready     = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = $urandom & 32'h0000_3FFF;
      cycle();
    end
    bus.redirect_valid = 1'b0;
    chk("rand_progress", {31'b0, (deliv_cnt - d0) > 300}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "simulation time limit");
  end
endmodule
